mem_port_arbiter: RTL and testbench

Shares the single data-memory port between the CPU load/store unit and the switch input controller. Requests are granted round-robin. A granted requester holds the port for a multi-beat burst until it signals its last beat. Burst length is capped at MAX_HOLD beats whenever the other requester is waiting. Sits between both masters and the data memory; read data returns to whichever master issued the read.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_IO} arb_state_t;

  localparam int REQ_CPU    = 0;
  localparam int REQ_IO     = 1;
  localparam int NUM_REQ    = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN_IO : OWN_CPU;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both master ports and the memory port; slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
  logic              cpu_req, cpu_we, cpu_last, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              io_req, io_we, io_last, io_gnt, io_rvalid;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata, io_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_last, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  io_req, io_we, io_last, io_addr, io_wdata,
    output io_gnt, io_rvalid, io_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_last, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output io_req, io_we, io_last, io_addr, io_wdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single data-memory port, CPU LSU vs input controller.
// Bursts hold the port until last, capped at MAX_HOLD beats when the other side waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t          state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                last_io_q, last_io_d;   // 1: IO served last, CPU wins next tie
  logic [NUM_REQ-1:0]  rd_pend_q, rd_pend_d;

  logic [NUM_REQ-1:0]  req, we, last, gnt, acc;
  logic                own, oth, hold_sat, rel_last, rel_drop, rel_cap;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;

  always_comb begin
    req[REQ_CPU]  = bus.cpu_req;
    req[REQ_IO]   = bus.io_req;
    we[REQ_CPU]   = bus.cpu_we;
    we[REQ_IO]    = bus.io_we;
    last[REQ_CPU] = bus.cpu_last;
    last[REQ_IO]  = bus.io_last;
    gnt[REQ_CPU]  = (state_q == OWN_CPU);
    gnt[REQ_IO]   = (state_q == OWN_IO);
    acc           = gnt & req;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_io_d  = last_io_q;
    own        = (state_q == OWN_IO);
    oth        = ~own;
    // Counter saturates so a long uncontended burst is still capped once the other side arrives.
    hold_sat   = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    rel_last   = acc[own] & last[own];
    rel_drop   = ~req[own];
    rel_cap    = acc[own] & hold_sat & req[oth];
    rd_pend_d  = acc & ~we;
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (&req)              state_d = last_io_q ? OWN_CPU : OWN_IO;
        else if (req[REQ_CPU]) state_d = OWN_CPU;
        else if (req[REQ_IO])  state_d = OWN_IO;
      end
      default: begin
        if (rel_last || rel_drop || rel_cap) begin
          last_io_d  = own;
          hold_cnt_d = '0;
          if (req[oth])      state_d = own_state(oth);
          else if (rel_last) state_d = own_state(own);
          else               state_d = IDLE;
        end else if (acc[own] && !hold_sat) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_io_q  <= 1'b1;
      rd_pend_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_io_q  <= last_io_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (acc[REQ_CPU]) begin
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
    end else if (acc[REQ_IO]) begin
      addr_mux  = bus.io_addr;
      wdata_mux = bus.io_wdata;
    end
  end

  always_comb begin
    bus.mem_we     = |(acc & we);
    bus.mem_addr   = addr_mux;
    bus.mem_wdata  = wdata_mux;
    bus.cpu_gnt    = gnt[REQ_CPU];
    bus.io_gnt     = gnt[REQ_IO];
    // Read data follows the issuing master, independent of where the grant is now.
    bus.cpu_rvalid = rd_pend_q[REQ_CPU];
    bus.io_rvalid  = rd_pend_q[REQ_IO];
    bus.cpu_rdata  = rd_pend_q[REQ_CPU] ? bus.mem_rdata : '0;
    bus.io_rdata   = rd_pend_q[REQ_IO]  ? bus.mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: vector table, hand corner sequences, random traffic vs an ownership model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_port_arbiter #(.MAX_HOLD(MH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // model: owner 0 = nobody, 1 = CPU, 2 = IO
  int m_own = 0;
  int m_beats = 0;
  bit m_last_io = 1;
  bit m_pend_c = 0, m_pend_i = 0;

  logic        s_cg, s_ig, s_we, s_crv, s_irv;
  logic [31:0] s_addr, s_wd, s_crd, s_ird;

  typedef struct {
    logic [2:0]  c;      // {req, we, last}
    logic [31:0] ca, cw;
    logic [2:0]  i;
    logic [31:0] ia, iw, mrd;
    logic [4:0]  ectl;   // {cpu_gnt, io_gnt, mem_we, cpu_rvalid, io_rvalid}
    logic [31:0] ea, ew, ecrd, eird;
  } vec_t;
  vec_t tv[14];

  function automatic vec_t mkv(logic [2:0] c, logic [31:0] ca, cw, logic [2:0] i,
                               logic [31:0] ia, iw, mrd, logic [4:0] ectl,
                               logic [31:0] ea, ew, ecrd, eird);
    vec_t v;
    v.c = c; v.ca = ca; v.cw = cw; v.i = i; v.ia = ia; v.iw = iw; v.mrd = mrd;
    v.ectl = ectl; v.ea = ea; v.ew = ew; v.ecrd = ecrd; v.eird = eird;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic set_cpu(logic [2:0] c, logic [31:0] a, logic [31:0] d);
    {bus.cpu_req, bus.cpu_we, bus.cpu_last} = c;
    bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_io(logic [2:0] c, logic [31:0] a, logic [31:0] d);
    {bus.io_req, bus.io_we, bus.io_last} = c;
    bus.io_addr = a; bus.io_wdata = d;
  endtask

  // One clock: sample, compare with model, advance model, return just after the edge.
  task automatic cyc();
    bit r[3], l[3], rel, rel_a, ac, ai;
    int x, y;
    logic [4:0]  ectl;
    logic [31:0] ea, ew;
    @(negedge clk);
    s_cg = bus.cpu_gnt; s_ig = bus.io_gnt; s_we = bus.mem_we;
    s_crv = bus.cpu_rvalid; s_irv = bus.io_rvalid;
    s_addr = bus.mem_addr; s_wd = bus.mem_wdata; s_crd = bus.cpu_rdata; s_ird = bus.io_rdata;
    ac = (m_own == 1) && bus.cpu_req;
    ai = (m_own == 2) && bus.io_req;
    ectl = {m_own == 1, m_own == 2, (ac && bus.cpu_we) || (ai && bus.io_we), m_pend_c, m_pend_i};
    ea = ac ? bus.cpu_addr : ai ? bus.io_addr : 32'h0;
    ew = ac ? bus.cpu_wdata : ai ? bus.io_wdata : 32'h0;
    if (chk_en) begin
      chk("model_ctl", 64'({s_cg, s_ig, s_we, s_crv, s_irv}), 64'(ectl));
      chk("model_addr", 64'(s_addr), 64'(ea));
      chk("model_wdata", 64'(s_wd), 64'(ew));
      chk("model_rdata", {s_crd, s_ird}, {m_pend_c ? bus.mem_rdata : 32'h0,
                                          m_pend_i ? bus.mem_rdata : 32'h0});
    end
    m_pend_c = ac && !bus.cpu_we;
    m_pend_i = ai && !bus.io_we;
    r[1] = bus.cpu_req; r[2] = bus.io_req; l[1] = bus.cpu_last; l[2] = bus.io_last;
    if (reset) begin
      m_own = 0; m_beats = 0; m_last_io = 1; m_pend_c = 0; m_pend_i = 0;
    end else if (m_own == 0) begin
      if (r[1] && r[2]) m_own = m_last_io ? 1 : 2;
      else if (r[1])    m_own = 1;
      else if (r[2])    m_own = 2;
      m_beats = 0;
    end else begin
      x = m_own; y = 3 - x;
      rel_a = r[x] && l[x];
      rel = !r[x] || rel_a || (r[x] && (m_beats + 1 >= MH) && r[y]);
      if (rel) begin
        m_last_io = (x == 2);
        m_beats = 0;
        m_own = r[y] ? y : (rel_a ? x : 0);
      end else if (r[x]) m_beats++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = mkv(3'b000, 0, 0, 3'b000, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    tv[1]  = mkv(3'b000, 0, 0, 3'b110, 0, 'h5A, 0, 5'b00000, 0, 0, 0, 0);
    tv[2]  = mkv(3'b000, 0, 0, 3'b110, 0, 'h5A, 0, 5'b01100, 0, 'h5A, 0, 0);
    tv[3]  = mkv(3'b000, 0, 0, 3'b111, 4, 'h3C, 0, 5'b01100, 4, 'h3C, 0, 0);
    tv[4]  = mkv(3'b000, 0, 0, 3'b000, 0, 0, 0, 5'b01000, 0, 0, 0, 0);
    tv[5]  = mkv(3'b000, 0, 0, 3'b000, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    tv[6]  = mkv(3'b110, 'h100, 1, 3'b110, 'h200, 2, 0, 5'b00000, 0, 0, 0, 0);
    tv[7]  = mkv(3'b111, 'h100, 1, 3'b110, 'h200, 2, 0, 5'b10100, 'h100, 1, 0, 0);
    tv[8]  = mkv(3'b000, 0, 0, 3'b111, 'h200, 2, 0, 5'b01100, 'h200, 2, 0, 0);
    tv[9]  = mkv(3'b000, 0, 0, 3'b000, 0, 0, 0, 5'b01000, 0, 0, 0, 0);
    tv[10] = mkv(3'b110, 'h100, 1, 3'b110, 'h200, 2, 0, 5'b00000, 0, 0, 0, 0);
    tv[11] = mkv(3'b101, 'h10, 0, 3'b110, 'h200, 2, 'h1111, 5'b10000, 'h10, 0, 0, 0);
    tv[12] = mkv(3'b000, 0, 0, 3'b000, 0, 0, 'hDEADBEEF, 5'b01010, 0, 0, 'hDEADBEEF, 0);
    tv[13] = mkv(3'b000, 0, 0, 3'b000, 0, 0, 'hDEADBEEF, 5'b00000, 0, 0, 0, 0);

    reset = 1'b1;
    set_cpu(3'b000, 0, 0); set_io(3'b000, 0, 0); bus.mem_rdata = 0;
    cyc(); cyc();
    reset = 1'b0;
    chk_en = 1;

    foreach (tv[k]) begin
      set_cpu(tv[k].c, tv[k].ca, tv[k].cw);
      set_io(tv[k].i, tv[k].ia, tv[k].iw);
      bus.mem_rdata = tv[k].mrd;
      cyc();
      chk($sformatf("tv%0d_ctl", k), 64'({s_cg, s_ig, s_we, s_crv, s_irv}), 64'(tv[k].ectl));
      chk($sformatf("tv%0d_addr", k), 64'(s_addr), 64'(tv[k].ea));
      chk($sformatf("tv%0d_wdata", k), 64'(s_wd), 64'(tv[k].ew));
      chk($sformatf("tv%0d_rdata", k), {s_crd, s_ird}, {tv[k].ecrd, tv[k].eird});
    end

    // CPU 10-beat burst preempted after MH beats by a waiting IO, then resumed
    set_cpu(3'b110, 0, 0); set_io(3'b000, 0, 0);
    cyc();
    chk("pre_idle_gnt", 64'(s_cg), 64'(0));
    set_io(3'b110, 'h800, 'h77);
    for (int k = 0; k < 4; k++) begin
      set_cpu(3'b110, k * 4, k);
      cyc();
      chk($sformatf("pre_beat%0d", k), 64'({s_cg, s_ig, s_we}), 64'(3'b101));
      chk($sformatf("pre_addr%0d", k), 64'(s_addr), 64'(k * 4));
    end
    set_cpu(3'b110, 16, 4);
    cyc();
    chk("pre_io_gnt", 64'({s_cg, s_ig, s_addr}), {32'h0, 2'b01, 32'h800});
    set_io(3'b111, 'h804, 'h78);
    cyc();
    chk("pre_io_last", 64'({s_cg, s_ig}), 64'(2'b01));
    set_io(3'b000, 0, 0);
    for (int k = 4; k < 10; k++) begin
      set_cpu({2'b11, k == 9}, k * 4, k);
      cyc();
      chk($sformatf("resume%0d", k), 64'({s_cg, s_we, s_addr}), {30'h0, 2'b11, 32'(k * 4)});
    end
    set_cpu(3'b000, 0, 0);
    cyc();

    // CPU abandons its burst while IO waits
    set_cpu(3'b110, 'h40, 'hAA);
    cyc(); cyc();
    chk("drop_cpu_beat", 64'({s_cg, s_we}), 64'(2'b11));
    set_cpu(3'b010, 'h44, 'hBB); set_io(3'b110, 'h900, 'hCC);
    cyc();
    chk("drop_no_write", 64'({s_cg, s_ig, s_we}), 64'(3'b100));
    cyc();
    chk("drop_io_gnt", 64'({s_cg, s_ig, s_we, s_addr}), {29'h0, 3'b011, 32'h900});

    // reset during an IO read beat discards the pending read
    set_cpu(3'b000, 0, 0); set_io(3'b100, 'h904, 0);
    reset = 1'b1;
    cyc();
    chk("rst_mid_beat", 64'({s_ig, s_we}), 64'(2'b10));
    reset = 1'b0; set_io(3'b000, 0, 0); bus.mem_rdata = 'h12345678;
    cyc();
    chk("rst_after", 64'({s_cg, s_ig, s_we, s_crv, s_irv}), 64'(0));
    set_io(3'b110, 'h20, 'h5);
    cyc(); cyc();
    chk("rst_fresh_io", 64'({s_ig, s_we, s_addr}), {30'h0, 2'b11, 32'h20});

    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_cpu({$urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0},
              $urandom, $urandom);
      set_io({$urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0},
             $urandom, $urandom);
      bus.mem_rdata = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
